// File: rtl/sa_autosa_cdma_param_fifo.sv
// Parametrised single-clock FIFO for CDMA image/data paths.
// Write side: one-entry input register, reserve-then-write into a DEPTHxDW 1R1W array,
// registered ready derived from occupancy versus a runtime write limit.
// Read side: push is seen one cycle after the array write; a one-entry output register
// drives rd_req/rd_data with no bubble while streaming.
module sa_autosa_cdma_param_fifo #(
    parameter int unsigned DW        = 11,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned AW        = 7,
    parameter int unsigned AFULL_LVL = 120
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              wr_req,
    output logic              wr_ready,
    input  logic [DW-1:0]     wr_data,
    output logic              rd_req,
    input  logic              rd_ready,
    output logic [DW-1:0]     rd_data,
    input  logic              flush,
    input  logic [AW:0]       wr_limit,
    output logic [AW:0]       count,
    output logic              afull,
    input  logic [31:0]       pwrbus_ram_pd
);

    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

    // Write-side state
    logic              wr_ready_q;
    logic              wr_req_in_q;
    logic [DW-1:0]     wr_data_in_q;
    logic [CW-1:0]     count_q;
    logic              afull_q;
    logic [AW-1:0]     wr_adr_q;
    // Read-side state
    logic              rd_pushing_q;
    logic              rd_popping_q;
    logic [CW-1:0]     rd_count_q;
    logic [AW-1:0]     rd_adr_q;
    logic              rd_req_q;
    logic [DW-1:0]     rd_data_q;
    // Storage array
    logic [DW-1:0]     mem [DEPTH];

    logic [CW-1:0]     eff_limit;
    logic              wr_accept;
    logic              wr_reserve;
    logic              wr_in_d;
    logic [CW-1:0]     count_d;
    logic [CW:0]       total_d;
    logic              wr_ready_d;
    logic              rd_pop;
    logic              rd_load;
    logic [CW-1:0]     rd_count_d;

    // Power-down bus is a hint to the memory macro; the flop array has no use for it.
    logic              unused_pd;
    assign unused_pd = ^pwrbus_ram_pd;

    // Next-state for occupancy, ready and the read-side refill decision
    always_comb begin
        eff_limit  = ((wr_limit == '0) || (wr_limit > DEPTH_C)) ? DEPTH_C : wr_limit;
        wr_accept  = wr_req & wr_ready_q;
        wr_reserve = wr_req_in_q & (count_q < DEPTH_C);
        // Input register stays occupied by a new beat or by a beat that could not reserve
        wr_in_d    = wr_accept | (wr_req_in_q & ~wr_reserve);
        // Pops reach the write side one cycle late
        count_d    = count_q + CW'(wr_reserve) - CW'(rd_popping_q);
        // Ready counts the beat parked in the input register so at most eff_limit are taken
        total_d    = {1'b0, count_d} + (CW + 1)'(wr_in_d);
        wr_ready_d = total_d < {1'b0, eff_limit};
        rd_pop     = rd_req_q & rd_ready;
        // Refill the output register whenever it is free or being emptied this cycle
        rd_load    = (rd_count_q != '0) & (~rd_req_q | rd_ready);
        rd_count_d = rd_count_q + CW'(rd_pushing_q) - CW'(rd_load);
    end

    // Write-side registers; flush overrides any concurrent transfer
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ready_q   <= 1'b1;
            wr_req_in_q  <= 1'b0;
            wr_data_in_q <= '0;
            count_q      <= '0;
            afull_q      <= 1'b0;
            wr_adr_q     <= '0;
        end else if (flush) begin
            wr_ready_q   <= 1'b1;
            wr_req_in_q  <= 1'b0;
            count_q      <= '0;
            afull_q      <= 1'b0;
            wr_adr_q     <= '0;
        end else begin
            wr_ready_q  <= wr_ready_d;
            wr_req_in_q <= wr_in_d;
            if (wr_accept) begin
                wr_data_in_q <= wr_data;
            end
            count_q <= count_d;
            afull_q <= count_d >= AFULL_C;
            if (wr_reserve) begin
                wr_adr_q <= wr_adr_q + 1'b1;
            end
        end
    end

    // Storage write of a reserved beat
    always_ff @(posedge clk) begin
        if (wr_reserve && !flush) begin
            mem[wr_adr_q] <= wr_data_in_q;
        end
    end

    // Read-side control: delayed push/pop flags, visible count, head pointer, valid
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rd_pushing_q <= 1'b0;
            rd_popping_q <= 1'b0;
            rd_count_q   <= '0;
            rd_adr_q     <= '0;
            rd_req_q     <= 1'b0;
        end else if (flush) begin
            rd_pushing_q <= 1'b0;
            rd_popping_q <= 1'b0;
            rd_count_q   <= '0;
            rd_adr_q     <= '0;
            rd_req_q     <= 1'b0;
        end else begin
            rd_pushing_q <= wr_reserve;
            rd_popping_q <= rd_pop;
            rd_count_q   <= rd_count_d;
            if (rd_load) begin
                rd_adr_q <= rd_adr_q + 1'b1;
            end
            rd_req_q <= rd_load | (rd_req_q & ~rd_ready);
        end
    end

    // Output data register; only read when the array holds a visible entry
    always_ff @(posedge clk) begin
        if (rd_load && !flush) begin
            rd_data_q <= mem[rd_adr_q];
        end
    end

    assign wr_ready = wr_ready_q;
    assign rd_req   = rd_req_q;
    assign rd_data  = rd_data_q;
    assign count    = count_q;
    assign afull    = afull_q;

    a_count_max: assert property (@(posedge clk) disable iff (!reset_) count_q <= DEPTH_C);

endmodule

// File: tb/tb_sa_autosa_cdma_param_fifo.sv
// Bench for sa_autosa_cdma_param_fifo: randomized traffic against a counting model
// (accept/pop histories plus a data queue), with directed latency, fill, limit, flush
// and reset scenarios carrying hand-computed expectations.
module tb_sa_autosa_cdma_param_fifo;

    localparam int DW    = 11;
    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int AFL   = 120;
    localparam int CW    = AW + 1;

    logic          clk = 1'b0;
    logic          reset_;
    logic          wr_req;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_req;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          flush;
    logic [CW-1:0] wr_limit;
    logic [CW-1:0] count;
    logic          afull;
    logic [31:0]   pwrbus_ram_pd;

    always #5 clk = ~clk;

    sa_autosa_cdma_param_fifo #(
        .DW        (DW),
        .DEPTH     (DEPTH),
        .AW        (AW),
        .AFULL_LVL (AFL)
    ) dut (
        .clk           (clk),
        .reset_        (reset_),
        .wr_req        (wr_req),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .rd_req        (rd_req),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .flush         (flush),
        .wr_limit      (wr_limit),
        .count         (count),
        .afull         (afull),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );

    int checks = 0;
    int errors = 0;

    // Model: cumulative accepts/pops after each edge since the last clear, plus data order
    int            acc_h[$];
    int            pop_h[$];
    int            acc_n = 0;
    int            pop_n = 0;
    int            total_pops = 0;
    int            eff_prev = DEPTH;
    logic [DW-1:0] dq[$];
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int eff(input logic [CW-1:0] w);
        if (w == 0 || w > DEPTH) return DEPTH;
        return int'(w);
    endfunction

    function automatic int accb(input int d);
        int i;
        i = acc_h.size() - 1 - d;
        return (i < 0) ? 0 : acc_h[i];
    endfunction

    function automatic int popb(input int d);
        int i;
        i = pop_h.size() - 1 - d;
        return (i < 0) ? 0 : pop_h[i];
    endfunction

    // Record transfers at each edge and score popped data in order
    always @(posedge clk) begin
        if (reset_ && hold_v) begin
            chk("hold_rd_req", rd_req, 1);
            chk("hold_rd_data", rd_data, hold_d);
        end
        hold_v = reset_ && !flush && rd_req && !rd_ready;
        hold_d = rd_data;
        if (!reset_ || flush) begin
            acc_h.delete();
            pop_h.delete();
            dq.delete();
            acc_n = 0;
            pop_n = 0;
            eff_prev = DEPTH;
        end else begin
            if (rd_req && rd_ready) begin
                if (dq.size() == 0) begin
                    chk("pop_nonempty", 0, 1);
                end else begin
                    chk("pop_data", rd_data, dq.pop_front());
                end
                pop_n++;
                total_pops++;
            end
            if (wr_req && wr_ready) begin
                dq.push_back(wr_data);
                acc_n++;
            end
            acc_h.push_back(acc_n);
            pop_h.push_back(pop_n);
            eff_prev = eff(wr_limit);
        end
    end

    // Compare registered outputs against the model every cycle out of reset
    always @(negedge clk) begin
        int tot;
        int cnt;
        int vis;
        if (reset_) begin
            tot = accb(0) - popb(1);
            cnt = accb(1) - popb(1);
            vis = accb(3) - popb(0);
            chk("m_wr_ready", wr_ready, (tot < eff_prev) ? 1 : 0);
            chk("m_count", count, cnt);
            chk("m_afull", afull, (cnt >= AFL) ? 1 : 0);
            chk("m_rd_req", rd_req, (vis > 0) ? 1 : 0);
        end
    end

    task automatic drain(input string nm);
        int ok;
        ok = 0;
        rd_ready = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (count == 0 && !rd_req && dq.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk(nm, ok, 1);
        rd_ready = 1'b0;
    endtask

    initial begin
        int n;
        int base;
        int sent;
        int ok;
        reset_        = 1'b0;
        wr_req        = 1'b0;
        wr_data       = '0;
        rd_ready      = 1'b0;
        flush         = 1'b0;
        wr_limit      = '0;
        pwrbus_ram_pd = '0;
        repeat (3) @(negedge clk);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_count", count, 0);
        chk("rst_afull", afull, 0);
        reset_ = 1'b1;
        repeat (2) @(negedge clk);

        // T1 latency: accept at edge N, visible after N+3
        wr_req  = 1'b1;
        wr_data = 11'h5A5;
        @(negedge clk);
        wr_req = 1'b0;
        @(negedge clk);
        chk("t1_count_n1", count, 1);
        chk("t1_rd_req_n1", rd_req, 0);
        @(negedge clk);
        chk("t1_rd_req_n2", rd_req, 0);
        @(negedge clk);
        chk("t1_rd_req_n3", rd_req, 1);
        chk("t1_rd_data", rd_data, 11'h5A5);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        chk("t1_rd_req_n4", rd_req, 0);
        @(negedge clk);
        chk("t1_count_n5", count, 0);

        // T2 fill with reads stalled
        n = 0;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            wr_req  = 1'b1;
            wr_data = DW'(i + 7);
            if (wr_ready) n++;
        end
        @(negedge clk);
        wr_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_accepted", n, DEPTH);
        chk("t2_wr_ready", wr_ready, 0);
        chk("t2_count", count, DEPTH);
        chk("t2_afull", afull, 1);
        drain("t2_drain");

        // T3 wrap: 300 incrementing beats, random read stalls
        base = total_pops;
        sent = 0;
        for (int c = 0; c < 3000 && sent < 300; c++) begin
            @(negedge clk);
            rd_ready = 1'($urandom % 2);
            if ($urandom % 4 != 0) begin
                wr_req  = 1'b1;
                wr_data = DW'(sent);
                if (wr_ready) sent++;
            end else begin
                wr_req = 1'b0;
            end
        end
        @(negedge clk);
        wr_req = 1'b0;
        chk("t3_sent", sent, 300);
        drain("t3_drain");
        chk("t3_pops", total_pops - base, 300);

        // T4 runtime write limit
        wr_limit = CW'(10);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            wr_req  = 1'b1;
            wr_data = DW'(i + 400);
            if (wr_ready) n++;
        end
        @(negedge clk);
        wr_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_lim_accepted", n, 10);
        chk("t4_lim_count", count, 10);
        chk("t4_lim_wr_ready", wr_ready, 0);
        wr_limit = '0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            wr_req  = 1'b1;
            wr_data = DW'(i + 600);
            if (wr_ready) n++;
        end
        @(negedge clk);
        wr_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_full_accepted", n, DEPTH);
        chk("t4_full_count", count, DEPTH);
        drain("t4_drain");

        // T5 flush with concurrent write and read
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            wr_req  = 1'b1;
            wr_data = DW'(i + 900);
        end
        @(negedge clk);
        wr_req = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_pre_rd_req", rd_req, 1);
        chk("t5_pre_count", count, 40);
        flush    = 1'b1;
        wr_req   = 1'b1;
        wr_data  = 11'h7FF;
        rd_ready = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        wr_req   = 1'b0;
        rd_ready = 1'b0;
        chk("t5_count", count, 0);
        chk("t5_rd_req", rd_req, 0);
        chk("t5_wr_ready", wr_ready, 1);
        wr_req  = 1'b1;
        wr_data = 11'h123;
        @(negedge clk);
        wr_req = 1'b0;
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rd_req) begin
                ok = 1;
                break;
            end
        end
        chk("t5_rd_req_after", ok, 1);
        chk("t5_rd_data", rd_data, 11'h123);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_empty_rd_req", rd_req, 0);
        chk("t5_empty_count", count, 0);

        // T6 asynchronous reset mid-burst
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            wr_req   = 1'b1;
            wr_data  = DW'(i + 1200);
            rd_ready = 1'($urandom % 2);
        end
        @(negedge clk);
        wr_req   = 1'b0;
        rd_ready = 1'b0;
        #2 reset_ = 1'b0;
        #1;
        chk("t6_wr_ready", wr_ready, 1);
        chk("t6_rd_req", rd_req, 0);
        chk("t6_count", count, 0);
        chk("t6_afull", afull, 0);
        repeat (2) @(negedge clk);
        reset_ = 1'b1;
        base = total_pops;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_req  = 1'b1;
            wr_data = DW'(16 + i);
        end
        @(negedge clk);
        wr_req = 1'b0;
        drain("t6_drain");
        chk("t6_pops", total_pops - base, 3);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
